// File: rtl/tt_um_javibajocero_top.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_javibajocero_top
// Brief    : Programmable PWM / timer with a 4-register write-only byte
//            configuration port. uo_out shows the live counter; uio[7:4]
//            carry the PWM output, the wrap pulse and the run status.
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_javibajocero_top #(
  parameter logic [7:0] RESET_PERIOD = 8'hFF,
  parameter logic [7:0] RESET_DUTY   = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,    // active-high asynchronous reset despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] c_ADDR_PERIOD   = 2'd0;
  localparam logic [1:0] c_ADDR_DUTY     = 2'd1;
  localparam logic [1:0] c_ADDR_CTRL     = 2'd2;
  localparam logic [1:0] c_ADDR_PRESCALE = 2'd3;

  // Configuration registers
  logic [7:0] r_period;
  logic [7:0] r_duty;
  logic [7:0] r_prescale;
  logic       r_en;
  logic       r_inv;

  // Timer state
  logic [7:0] r_count;
  logic [7:0] r_pre;
  logic       r_wrap;

  // Decoded write strobes
  logic       w_we;
  logic [1:0] w_addr;
  logic       w_clr_wr;
  logic       w_tick;
  logic       w_pwm;
  logic       w_unused_bits;

  assign w_we     = ena & uio_in[2];
  assign w_addr   = uio_in[1:0];
  // clr is a strobe: it acts on the write edge only and is never stored
  assign w_clr_wr = w_we & (w_addr == c_ADDR_CTRL) & ui_in[2];
  // Tick decision uses the pre-write register values on a write edge
  assign w_tick   = r_en & (r_pre == r_prescale);

  assign w_unused_bits = &{1'b0, uio_in[7:3]};

  // Register file: byte writes gated by ena and the level-sampled write enable
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_period   <= RESET_PERIOD;
      r_duty     <= RESET_DUTY;
      r_prescale <= 8'h00;
      r_en       <= 1'b0;
      r_inv      <= 1'b0;
    end else if (w_we) begin
      case (w_addr)
        c_ADDR_PERIOD:   r_period   <= ui_in;
        c_ADDR_DUTY:     r_duty     <= ui_in;
        c_ADDR_CTRL: begin
          r_en  <= ui_in[0];
          r_inv <= ui_in[1];
        end
        c_ADDR_PRESCALE: r_prescale <= ui_in;
        default:         r_period   <= r_period;
      endcase
    end
  end

  // Prescaler, counter and wrap pulse; a clearing CTRL write beats any tick
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_count <= 8'h00;
      r_pre   <= 8'h00;
      r_wrap  <= 1'b0;
    end else if (!ena) begin
      r_wrap <= 1'b0;
    end else if (w_clr_wr) begin
      r_count <= 8'h00;
      r_pre   <= 8'h00;
      r_wrap  <= 1'b0;
    end else if (r_en) begin
      if (w_tick) begin
        r_pre <= 8'h00;
        // >= rather than == so lowering PERIOD below COUNT wraps immediately
        if (r_count >= r_period) begin
          r_count <= 8'h00;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= r_count + 8'd1;
          r_wrap  <= 1'b0;
        end
      end else begin
        r_pre  <= r_pre + 8'd1;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // PWM is purely combinational from registered state
  always_comb begin
    w_pwm = (r_count < r_duty) ^ r_inv;
  end

  assign uo_out  = r_count;
  assign uio_out = {1'b0, r_en, r_wrap, w_pwm, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_javibajocero_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_javibajocero_top
// Brief    : Directed self-checking bench for the PWM / timer top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_um_javibajocero_top;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests;
  int fails;

  tt_um_javibajocero_top #(
    .RESET_PERIOD(8'hFF),
    .RESET_DUTY  (8'h80)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 ns past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle register write
  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    ui_in  = data;
    uio_in = {5'b00000, 1'b1, addr};
    step(1);
    uio_in = 8'h00;
    ui_in  = 8'h00;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1;
    tests++;
    if (uo_out !== 8'h00) begin
      fails++; $display("FAIL reset_uo_out got=%h exp=%h", uo_out, 8'h00);
    end
    tests++;
    if (uio_out !== 8'h10) begin
      fails++; $display("FAIL reset_uio_out got=%h exp=%h", uio_out, 8'h10);
    end
    tests++;
    if (uio_oe !== 8'hF0) begin
      fails++; $display("FAIL reset_uio_oe got=%h exp=%h", uio_oe, 8'hF0);
    end
    step(3);
    rst_n = 1'b0;
    step(10);
    tests++;
    if (uo_out !== 8'h00 || uio_out !== 8'h10) begin
      fails++; $display("FAIL idle_after_reset got uo=%h uio=%h exp uo=00 uio=10", uo_out, uio_out);
    end
  endtask

  task automatic test_count;
    logic [7:0] exp_cnt;
    wr(2'd0, 8'd4);
    wr(2'd3, 8'd0);
    wr(2'd2, 8'h01);
    exp_cnt = 8'd0;
    tests++;
    if (uo_out !== 8'd0 || uio_out[6] !== 1'b1) begin
      fails++; $display("FAIL count_start got cnt=%0d run=%b exp cnt=0 run=1", uo_out, uio_out[6]);
    end
    for (int i = 0; i < 12; i++) begin
      step(1);
      exp_cnt = (exp_cnt == 8'd4) ? 8'd0 : exp_cnt + 8'd1;
      tests++;
      if (uo_out !== exp_cnt || uio_out[5] !== (exp_cnt == 8'd0)) begin
        fails++;
        $display("FAIL count_seq step=%0d got cnt=%0d wrap=%b exp cnt=%0d wrap=%b",
                 i, uo_out, uio_out[5], exp_cnt, (exp_cnt == 8'd0));
      end
    end
  endtask

  task automatic test_prescale;
    int highs;
    int exp_cnt;
    wr(2'd0, 8'd9);
    wr(2'd1, 8'd3);
    wr(2'd3, 8'd2);
    wr(2'd2, 8'h05);
    highs = 0;
    for (int k = 0; k < 30; k++) begin
      exp_cnt = (k / 3) % 10;
      tests++;
      if (uo_out !== exp_cnt[7:0] || uio_out[4] !== (exp_cnt < 3)) begin
        fails++;
        $display("FAIL prescale k=%0d got cnt=%0d pwm=%b exp cnt=%0d pwm=%b",
                 k, uo_out, uio_out[4], exp_cnt, (exp_cnt < 3));
      end
      if (uio_out[4] === 1'b1) highs++;
      step(1);
    end
    tests++;
    if (highs != 9) begin
      fails++; $display("FAIL pwm_high_cycles got=%0d exp=9", highs);
    end
  endtask

  task automatic test_duty_limits;
    int bad;
    // DUTY=0: constant low
    wr(2'd1, 8'h00);
    bad = 0;
    for (int i = 0; i < 32; i++) begin if (uio_out[4] !== 1'b0) bad++; step(1); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL duty0_pwm bad_cycles=%0d exp=0", bad); end
    // DUTY=FF above PERIOD=9: constant high
    wr(2'd1, 8'hFF);
    bad = 0;
    for (int i = 0; i < 32; i++) begin if (uio_out[4] !== 1'b1) bad++; step(1); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL dutyff_pwm bad_cycles=%0d exp=0", bad); end
    // Invert both levels
    wr(2'd2, 8'h03);
    bad = 0;
    for (int i = 0; i < 32; i++) begin if (uio_out[4] !== 1'b0) bad++; step(1); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL inv_dutyff_pwm bad_cycles=%0d exp=0", bad); end
    wr(2'd1, 8'h00);
    bad = 0;
    for (int i = 0; i < 32; i++) begin if (uio_out[4] !== 1'b1) bad++; step(1); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL inv_duty0_pwm bad_cycles=%0d exp=0", bad); end
    wr(2'd2, 8'h01);
    wr(2'd1, 8'h80);
  endtask

  task automatic test_period_shrink;
    wr(2'd3, 8'd0);
    wr(2'd0, 8'd9);
    wr(2'd2, 8'h05);
    step(7);
    tests++;
    if (uo_out !== 8'd7) begin fails++; $display("FAIL shrink_pre got=%0d exp=7", uo_out); end
    // Write edge still ticks with the old PERIOD=9
    wr(2'd0, 8'd3);
    tests++;
    if (uo_out !== 8'd8 || uio_out[5] !== 1'b0) begin
      fails++; $display("FAIL shrink_write_edge got cnt=%0d wrap=%b exp cnt=8 wrap=0", uo_out, uio_out[5]);
    end
    step(1);
    tests++;
    if (uo_out !== 8'd0 || uio_out[5] !== 1'b1) begin
      fails++; $display("FAIL shrink_wrap got cnt=%0d wrap=%b exp cnt=0 wrap=1", uo_out, uio_out[5]);
    end
    step(1);
    tests++;
    if (uo_out !== 8'd1 || uio_out[5] !== 1'b0) begin
      fails++; $display("FAIL shrink_after got cnt=%0d wrap=%b exp cnt=1 wrap=0", uo_out, uio_out[5]);
    end
  endtask

  task automatic test_clear;
    wr(2'd2, 8'h05);
    tests++;
    if (uo_out !== 8'd0 || uio_out[5] !== 1'b0) begin
      fails++; $display("FAIL clr_now got cnt=%0d wrap=%b exp cnt=0 wrap=0", uo_out, uio_out[5]);
    end
    step(1);
    tests++;
    if (uo_out !== 8'd1) begin fails++; $display("FAIL clr_continue got=%0d exp=1", uo_out); end
  endtask

  task automatic test_ena_low;
    ena = 1'b0;
    wr(2'd0, 8'h20);
    wr(2'd1, 8'h00);
    step(3);
    tests++;
    if (uo_out !== 8'd1 || uio_out[4] !== 1'b1 || uio_out[5] !== 1'b0) begin
      fails++; $display("FAIL ena_low_hold got cnt=%0d pwm=%b wrap=%b exp cnt=1 pwm=1 wrap=0",
                        uo_out, uio_out[4], uio_out[5]);
    end
    ena = 1'b1;
    step(3);
    // PERIOD must still be 3: count 2,3 then wrap to 0
    tests++;
    if (uo_out !== 8'd0 || uio_out[5] !== 1'b1) begin
      fails++; $display("FAIL ena_low_period got cnt=%0d wrap=%b exp cnt=0 wrap=1", uo_out, uio_out[5]);
    end
  endtask

  task automatic test_reset_midcount;
    wr(2'd0, 8'd9);
    wr(2'd2, 8'h05);
    step(5);
    tests++;
    if (uo_out !== 8'd5) begin fails++; $display("FAIL midrst_pre got=%0d exp=5", uo_out); end
    rst_n = 1'b1;
    #1;
    tests++;
    if (uo_out !== 8'd0 || uio_out !== 8'h10) begin
      fails++; $display("FAIL midrst_async got uo=%h uio=%h exp uo=00 uio=10", uo_out, uio_out);
    end
    step(1);
    rst_n = 1'b0;
    step(5);
    tests++;
    if (uo_out !== 8'd0 || uio_out[6] !== 1'b0) begin
      fails++; $display("FAIL midrst_idle got cnt=%0d run=%b exp cnt=0 run=0", uo_out, uio_out[6]);
    end
    // PERIOD back to FF: ten ticks reach 10 instead of wrapping at 9
    wr(2'd2, 8'h01);
    step(10);
    tests++;
    if (uo_out !== 8'd10) begin fails++; $display("FAIL midrst_period got=%0d exp=10", uo_out); end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #2;
    test_reset;
    test_count;
    test_prescale;
    test_duty_limits;
    test_period_shrink;
    test_clear;
    test_ena_low;
    test_reset_midcount;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_um_javibajocero_top.md
Name: tt_um_javibajocero_top

Overview:
- Tiny Tapeout user-project top: a programmable PWM / timer block with a 4-register write-only configuration interface.
- Parallel byte writes configure the block through ui_in / uio_in.
- uo_out shows the live counter value.
- uio[7:4] drive the PWM output, the wrap pulse and a status bit.
- Sits directly under the TT harness; no submodules are required.

Parameters:
- RESET_PERIOD, 8'hFF, reset value of the PERIOD register.
- RESET_DUTY, 8'h80, reset value of the DUTY register.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst_n  input  1  asynchronous, active-high reset. rst_n=1 resets immediately, independent of clk. Port name kept per codebase convention.
- ena  input  1  design enable. When 0, all state holds and writes are ignored.
- ui_in  input  8  write data byte.
- uio_in  input  8  [1:0] register address; [2] write enable, level-sampled each clock; [7:3] ignored.
- uo_out  output  8  current counter value (COUNT).
- uio_out  output  8  [4] PWM; [5] WRAP pulse; [6] RUN status (CTRL.en); [7] and [3:0] = 0.
- uio_oe  output  8  constant 8'hF0.

Behaviour:
- Registers, written on a clock edge when ena=1 and uio_in[2]=1, selected by uio_in[1:0]:
  - 0 PERIOD (reset RESET_PERIOD).
  - 1 DUTY (reset RESET_DUTY).
  - 2 CTRL (reset 0): bit0 en, bit1 inv, bit2 clr. clr is self-clearing and not stored; bits 7:3 are ignored and read as 0.
  - 3 PRESCALE (reset 0).
- Reset values: COUNT=0, prescaler counter PRE=0, WRAP=0, uo_out=0, uio_out=8'h00 except bit4.
  - With reset DUTY=0x80 and COUNT=0, PWM=1 during reset (inv=0).
- Tick generation:
  - Active when ena=1 and CTRL.en=1.
  - If PRE==PRESCALE: tick=1 and PRE<=0. Otherwise PRE<=PRE+1.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
- Counter, on each tick:
  - If COUNT>=PERIOD: COUNT<=0 and WRAP<=1 for exactly one cycle.
  - Otherwise COUNT<=COUNT+1 and WRAP<=0.
  - Without a tick, WRAP<=0.
  - Counting period is PERIOD+1 ticks. PERIOD=0 keeps COUNT=0 and pulses WRAP on every tick.
- Lowering PERIOD below the current COUNT causes a wrap on the next tick; there is no runaway to 255.
- PWM:
  - PWM = (COUNT < DUTY) XOR CTRL.inv, combinational from registers only.
  - DUTY=0 gives constant 0. DUTY>PERIOD gives constant 1 (both before inv).
- Write to CTRL with bit2=1: COUNT<=0, PRE<=0, WRAP<=0 on that edge, overriding any tick in the same cycle. en/inv take the written values.
- Write to CTRL with en=0: COUNT and PRE freeze at their current values, WRAP goes to 0.
- New register values take effect for comparisons on the cycle after the write edge. A tick on the write edge uses the old values.
- ena=0: no register writes, no counting, WRAP<=0. Outputs keep driving current values.
- Reset asserted mid-operation: all state returns to reset values immediately. Counting resumes only after a CTRL write sets en=1.
- Latency: COUNT updates one clock after a tick. The uo_out change is visible on the same edge.

Test Plan:
- Reset (rst_n=1 for 3 cycles, then 0) -> uo_out=0x00; uio_out=0x10; uio_oe=0xF0. Idle 10 cycles with en=0: uo_out stays 0.
- Write PERIOD=4, PRESCALE=0, CTRL=0x01 -> uo_out sequence 0,1,2,3,4,0,1,… WRAP high for one cycle exactly when COUNT returns to 0.
- PRESCALE=2, PERIOD=9, DUTY=3, CTRL=0x01 -> COUNT advances every 3 cycles. PWM high while COUNT 0–2, low for 3–9: 9 cycles high per 30-cycle period.
- DUTY=0 -> PWM constant 0. DUTY=0xFF with PERIOD=9 -> PWM constant 1. CTRL=0x03 (inv) -> both levels invert.
- COUNT=7 with PERIOD=9, then write PERIOD=3 -> next tick gives COUNT=0 plus a WRAP pulse. CTRL=0x05 mid-count -> COUNT=0 on the next cycle and continues counting. Writes with ena=0 -> registers unchanged.
- Assert rst_n=1 mid-count at COUNT=5 -> COUNT=0 and PERIOD back to 0xFF without waiting for a clock edge. CTRL.en=0 after reset -> counter idle.
